// File: rtl/axis_fifo_pkg.sv
// Shared default widths and types for the AXI-Stream FIFO wrapper.
package axis_fifo_pkg;

  localparam int unsigned DefDepth     = 16;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefKeepWidth = (DefDataWidth / 8 > 0) ? DefDataWidth / 8 : 1;
  localparam int unsigned DefIdWidth   = 8;
  localparam int unsigned DefDestWidth = 8;
  localparam int unsigned DefUserWidth = 1;
  localparam int unsigned DefPtrWidth  = $clog2(DefDepth) + 1;

  typedef logic [DefPtrWidth-1:0] ptr_t;
  typedef logic [DefPtrWidth-1:0] count_t;

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic [DefKeepWidth-1:0] keep;
    logic                    last;
    logic [DefIdWidth-1:0]   id;
    logic [DefDestWidth-1:0] dest;
    logic [DefUserWidth-1:0] user;
  } beat_t;

endpackage

// File: rtl/axis_async_fifo_wrapper_if.sv
// AXI-Stream bundle: master drives payload and valid, slave drives ready.
interface axis_async_fifo_wrapper_if
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned KEEP_WIDTH = DefKeepWidth,
  parameter int unsigned ID_WIDTH   = DefIdWidth,
  parameter int unsigned DEST_WIDTH = DefDestWidth,
  parameter int unsigned USER_WIDTH = DefUserWidth
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tlast, tid, tdest, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tid, tdest, tuser, tvalid, output tready);

endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage; the registered read port doubles as the output stage.
module axis_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AddrWidth = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read data holds when rd_en_i is low, so payload stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_async_fifo_wrapper.sv
// Single-clock AXI-Stream FIFO with first-word-fall-through registered output and fill status.
module axis_async_fifo_wrapper
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned KEEP_WIDTH = DefKeepWidth,
  parameter int unsigned ID_WIDTH   = DefIdWidth,
  parameter int unsigned DEST_WIDTH = DefDestWidth,
  parameter int unsigned USER_WIDTH = DefUserWidth,
  localparam int unsigned PtrWidth  = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  axis_async_fifo_wrapper_if.slave  s_axis,
  axis_async_fifo_wrapper_if.master m_axis,
  output logic [PtrWidth-1:0]       sink_depth,
  output logic                      sink_overflow,
  output logic                      sink_good_frame,
  output logic [PtrWidth-1:0]       source_depth,
  output logic                      source_good_frame
);

  localparam int unsigned AddrWidth = PtrWidth - 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } fifo_beat_t;

  localparam int unsigned BeatWidth = $bits(fifo_beat_t);

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0] depth_q, depth_d;
  logic                m_valid_q, m_valid_d;
  logic                sink_frame_q, src_frame_q;
  logic                full, push, pop, load;
  fifo_beat_t          wr_beat, rd_beat;

  // rd_ptr addresses the beat currently in the output register, so count includes it.
  assign full = (wr_ptr_q[AddrWidth-1:0] == rd_ptr_q[AddrWidth-1:0]) &&
                (wr_ptr_q[AddrWidth] != rd_ptr_q[AddrWidth]);

  assign s_axis.tready = !full && !reset;
  assign push          = s_axis.tvalid && s_axis.tready;
  assign pop           = m_valid_q && m_axis.tready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PtrWidth'(push);
    rd_ptr_d  = rd_ptr_q + PtrWidth'(pop);
    depth_d   = wr_ptr_d - rd_ptr_d;
    // Compare against registered wr_ptr so a same-cycle push is never bypassed.
    m_valid_d = (rd_ptr_d != wr_ptr_q);
    load      = m_valid_d && (pop || !m_valid_q);
  end

  always_comb begin
    wr_beat      = '0;
    wr_beat.data = s_axis.tdata;
    wr_beat.keep = s_axis.tkeep;
    wr_beat.last = s_axis.tlast;
    wr_beat.id   = s_axis.tid;
    wr_beat.dest = s_axis.tdest;
    wr_beat.user = s_axis.tuser;
  end

  axis_fifo_ram #(
    .DEPTH(DEPTH),
    .WIDTH(BeatWidth)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (push),
    .wr_addr_i(wr_ptr_q[AddrWidth-1:0]),
    .wr_data_i(wr_beat),
    .rd_en_i  (load),
    .rd_addr_i(rd_ptr_d[AddrWidth-1:0]),
    .rd_data_o(rd_beat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      depth_q      <= '0;
      m_valid_q    <= 1'b0;
      sink_frame_q <= 1'b0;
      src_frame_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      depth_q      <= depth_d;
      m_valid_q    <= m_valid_d;
      sink_frame_q <= push && s_axis.tlast;
      src_frame_q  <= pop && rd_beat.last;
    end
  end

  assign m_axis.tdata  = rd_beat.data;
  assign m_axis.tkeep  = rd_beat.keep;
  assign m_axis.tlast  = rd_beat.last;
  assign m_axis.tid    = rd_beat.id;
  assign m_axis.tdest  = rd_beat.dest;
  assign m_axis.tuser  = rd_beat.user;
  assign m_axis.tvalid = m_valid_q;

  assign sink_depth        = depth_q;
  assign source_depth      = depth_q;
  assign sink_overflow     = 1'b0;
  assign sink_good_frame   = sink_frame_q;
  assign source_good_frame = src_frame_q;

endmodule

// File: tb/tb_axis_async_fifo_wrapper.sv
// Bench for axis_async_fifo_wrapper: queue-based reference model, vector table and corner sequences.
module tb_axis_async_fifo_wrapper;
  import axis_fifo_pkg::*;

  localparam int unsigned Depth = DefDepth;

  typedef struct {
    beat_t       b;
    int unsigned stamp;
  } entry_t;

  typedef struct {
    bit         vld;
    logic [7:0] data;
    bit         last;
    bit         rdy;
    bit         exp_valid;
    logic [7:0] exp_data;
    int         exp_depth;
  } vec_t;

  logic   clk;
  logic   rst;
  count_t sink_depth, source_depth;
  logic   sink_overflow, sink_good_frame, source_good_frame;

  axis_async_fifo_wrapper_if s_if ();
  axis_async_fifo_wrapper_if m_if ();

  axis_async_fifo_wrapper dut (
    .clk              (clk),
    .reset            (rst),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .sink_depth       (sink_depth),
    .sink_overflow    (sink_overflow),
    .sink_good_frame  (sink_good_frame),
    .source_depth     (source_depth),
    .source_good_frame(source_good_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned edge_cnt = 0;
  entry_t      mq[$];
  logic [7:0]  out_log[$];
  logic [7:0]  in_log[$];
  bit          exp_valid = 1'b0;
  bit          exp_sgf, exp_srcgf;
  vec_t        vecs[11];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endfunction

  function automatic beat_t mk(logic [7:0] data, bit last, logic [7:0] id, logic [7:0] dest,
                               bit user);
    beat_t b;
    b.data = data;
    b.keep = 1'b1;
    b.last = last;
    b.id   = id;
    b.dest = dest;
    b.user = user;
    return b;
  endfunction

  task automatic drive(bit v, beat_t b);
    s_if.tvalid = v;
    s_if.tdata  = b.data;
    s_if.tkeep  = b.keep;
    s_if.tlast  = b.last;
    s_if.tid    = b.id;
    s_if.tdest  = b.dest;
    s_if.tuser  = b.user;
  endtask

  // One clock: update the model from the spec's rules, then compare every output.
  task automatic tick();
    bit     push, pop;
    beat_t  cur;
    entry_t e;
    push = s_if.tvalid && !rst && (mq.size() < Depth);
    pop  = exp_valid && m_if.tready && !rst;
    cur  = mk(s_if.tdata, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser);
    cur.keep = s_if.tkeep;
    if (m_if.tvalid && m_if.tready && !rst) out_log.push_back(m_if.tdata);
    @(posedge clk);
    edge_cnt++;
    exp_sgf   = push && cur.last;
    exp_srcgf = pop && mq[0].b.last;
    if (rst) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.b = cur;
        e.stamp = edge_cnt;
        mq.push_back(e);
      end
    end
    exp_valid = (mq.size() > 0) && (mq[0].stamp < edge_cnt);
    #1;
    chk("s_tready", s_if.tready, (!rst && mq.size() < Depth));
    chk("m_tvalid", m_if.tvalid, exp_valid);
    chk("sink_depth", sink_depth, mq.size());
    chk("source_depth", source_depth, mq.size());
    chk("sink_overflow", sink_overflow, 0);
    chk("sink_good_frame", sink_good_frame, exp_sgf);
    chk("source_good_frame", source_good_frame, exp_srcgf);
    if (exp_valid) begin
      chk("payload", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser},
          mq[0].b);
    end
  endtask

  initial begin
    int acc, sg, srcg, pushed;
    bit got;
    beat_t cap, b;

    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 2};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 2};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1};
    vecs[4]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    vecs[7]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 1};
    vecs[8]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h44, 2};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};

    rst = 1'b1;
    drive(1'b0, mk(8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    m_if.tready = 1'b0;
    tick();
    tick();
    chk("rst_payload", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser}, 0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].vld, mk(vecs[i].data, vecs[i].last, 8'h00, 8'h00, 1'b0));
      m_if.tready = vecs[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), m_if.tvalid, vecs[i].exp_valid);
      chk($sformatf("tbl%0d_depth", i), sink_depth, vecs[i].exp_depth);
      if (vecs[i].exp_valid) chk($sformatf("tbl%0d_data", i), m_if.tdata, vecs[i].exp_data);
    end

    // Ordered data with one idle cycle between beats
    out_log.delete();
    m_if.tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, mk(8'(i), 1'b0, 8'h00, 8'h00, 1'b0));
      tick();
      s_if.tvalid = 1'b0;
      tick();
    end
    for (int c = 0; c < 5; c++) tick();
    chk("ord_count", out_log.size(), 10);
    for (int i = 0; i < out_log.size() && i < 10; i++) chk("ord_data", out_log[i], i);

    // Fill to full, then pop while full, then drain
    out_log.delete();
    m_if.tready = 1'b0;
    acc = 0;
    for (int c = 0; c < 40 && s_if.tready; c++) begin
      drive(1'b1, mk(8'(8'h80 + c), 1'b0, 8'h00, 8'h00, 1'b0));
      if (s_if.tready) acc++;
      tick();
    end
    chk("fill_accepted", acc, 16);
    chk("fill_depth", sink_depth, 16);
    chk("fill_tready", s_if.tready, 0);
    drive(1'b1, mk(8'hC0, 1'b0, 8'h00, 8'h00, 1'b0));
    m_if.tready = 1'b1;
    tick();
    chk("fullpop_depth", sink_depth, 15);
    chk("fullpop_tready", s_if.tready, 1);
    m_if.tready = 1'b0;
    tick();
    chk("resume_depth", sink_depth, 16);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    for (int c = 0; c < 60 && sink_depth != 0; c++) tick();
    chk("drain_pops", out_log.size(), 17);
    chk("drain_depth", sink_depth, 0);

    // Sideband fields and frame pulses
    sg = 0;
    srcg = 0;
    got = 1'b0;
    cap = '0;
    drive(1'b1, mk(8'h5A, 1'b1, 8'd3, 8'd5, 1'b1));
    tick();
    sg += int'(sink_good_frame);
    srcg += int'(source_good_frame);
    s_if.tvalid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      sg += int'(sink_good_frame);
      srcg += int'(source_good_frame);
      if (m_if.tvalid && !got) begin
        got = 1'b1;
        cap = mk(m_if.tdata, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser);
      end
    end
    chk("sb_seen", got, 1);
    chk("sb_fields", cap, mk(8'h5A, 1'b1, 8'd3, 8'd5, 1'b1));
    chk("sb_sink_pulses", sg, 1);
    chk("sb_source_pulses", srcg, 1);

    // Reset with beats queued
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mk(8'(8'h60 + i), 1'b0, 8'h00, 8'h00, 1'b0));
      tick();
    end
    chk("prerst_depth", sink_depth, 5);
    rst = 1'b1;
    drive(1'b1, mk(8'h77, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
    rst = 1'b0;
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_depth", source_depth, 0);
    drive(1'b1, mk(8'hAA, 1'b0, 8'h00, 8'h00, 1'b0));
    tick();
    s_if.tvalid = 1'b0;
    tick();
    chk("postrst_valid", m_if.tvalid, 1);
    chk("postrst_data", m_if.tdata, 8'hAA);
    m_if.tready = 1'b1;
    tick();

    // Random backpressure across pointer wrap
    out_log.delete();
    in_log.delete();
    pushed = 0;
    for (int c = 0; c < 2000 && out_log.size() < 40; c++) begin
      b = mk(8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      b.keep = 1'($urandom);
      drive(pushed < 40, b);
      m_if.tready = 1'($urandom_range(0, 1));
      if (s_if.tvalid && s_if.tready) begin
        in_log.push_back(b.data);
        pushed++;
      end
      tick();
    end
    chk("rand_count", out_log.size(), 40);
    for (int i = 0; i < out_log.size() && i < in_log.size(); i++) begin
      chk("rand_data", out_log[i], in_log[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
